// File: rtl/bnn_layer_sched.sv
// bnn_layer_sched: inference sequencer for a binarised neural network.
// It opens a pixel window of NUM_PIX cycles and then starts each layer engine
// in turn, waiting for each engine's completion pulse before starting the next.
// When the fc engine finishes, it latches the class vector and pulses done.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start, abort   begin an inference (accepted only in IDLE); cancel one
//   din_ready      high while the pixel window is open
//   layer_start    one-hot, single-cycle start pulse to the active engine
//   layer_done     completion pulses from the engines
//   classes_in     result vector from the fc engine
//   classes        latched result of the last completed inference
//   conv1_done     high from conv1 completion until the next accepted start
//   busy, done     not-idle flag; single-cycle completion pulse
//   err            sticky watchdog flag (present only with BNN_SCHED_TIMEOUT_EN)
//
// Build option: define BNN_SCHED_TIMEOUT_EN to add the per-layer watchdog.
module bnn_layer_sched #(
  parameter int unsigned NUM_PIX        = 784,
  parameter int unsigned NUM_LAYERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  din_ready,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [9:0]            classes_in,
  output logic [9:0]            classes,
  output logic                  conv1_done,
  output logic                  busy,
  output logic                  done
`ifdef BNN_SCHED_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned PIX_W = 11;
  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LAYERS - 1);

`ifdef BNN_SCHED_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
  logic [WCNT_W-1:0] wcnt;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FIN} state_t;

  state_t           state;
  logic [PIX_W-1:0] pix_cnt;
  logic [IDX_W-1:0] idx;

  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_LAYERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      idx         <= '0;
      din_ready   <= 1'b0;
      layer_start <= '0;
      classes     <= '0;
      conv1_done  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef BNN_SCHED_TIMEOUT_EN
      wcnt        <= '0;
      err         <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low each cycle.
      layer_start <= '0;
      done        <= 1'b0;
      if (state != IDLE && abort) begin
        // Cancel: no done pulse, classes untouched, abort beats layer_done.
        state     <= IDLE;
        din_ready <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A start coinciding with abort is not accepted.
            if (start && !abort) begin
              state      <= LOAD;
              busy       <= 1'b1;
              din_ready  <= 1'b1;
              pix_cnt    <= '0;
              idx        <= '0;
              conv1_done <= 1'b0;
`ifdef BNN_SCHED_TIMEOUT_EN
              err        <= 1'b0;
`endif
            end
          end
          LOAD: begin
            if (pix_cnt == PIX_LAST) begin
              state       <= ISSUE;
              din_ready   <= 1'b0;
              layer_start <= onehot(idx);
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
          ISSUE: begin
            // Any done seen during the start cycle is deliberately ignored.
            state <= WAIT;
`ifdef BNN_SCHED_TIMEOUT_EN
            wcnt  <= '0;
`endif
          end
          WAIT: begin
            if (layer_done[idx]) begin
              if (idx == '0) conv1_done <= 1'b1;
              if (idx == IDX_LAST) begin
                state   <= FIN;
                classes <= classes_in;
                done    <= 1'b1;
              end else begin
                state       <= ISSUE;
                idx         <= idx + 1'b1;
                layer_start <= onehot(idx + 1'b1);
              end
            end
`ifdef BNN_SCHED_TIMEOUT_EN
            else if (wcnt == WCNT_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
`endif
          end
          FIN: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            din_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bnn_layer_sched.sv
// tb_bnn_layer_sched: randomized bench for bnn_layer_sched. Engines are modelled
// as fixed-latency responders; expected timing comes from the pixel count plus
// per-layer (start cycle + engine latency) arithmetic.
module tb_bnn_layer_sched;

  localparam int unsigned NP = 784;
  localparam int unsigned NL = 4;
`ifdef BNN_SCHED_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          din_ready, conv1_done, busy, done;
  logic [NL-1:0] layer_start, layer_done;
  logic [9:0]    classes_in, classes;
`ifdef BNN_SCHED_TIMEOUT_EN
  logic          err;
`endif

  int         vecs = 0;
  int         errs = 0;
  logic [9:0] prev_cls = '0;

  always #5 clk = ~clk;

  bnn_layer_sched #(.NUM_PIX(NP), .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .din_ready(din_ready), .layer_start(layer_start), .layer_done(layer_done),
    .classes_in(classes_in), .classes(classes), .conv1_done(conv1_done),
    .busy(busy), .done(done)
`ifdef BNN_SCHED_TIMEOUT_EN
    , .err(err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_din"}, 32'(din_ready), 0);
    chk({tag, "_lstart"}, 32'(layer_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // mode 0: normal, 1: abort together with fc done, 2: async reset in conv2 WAIT,
  // 3: conv2 engine never answers (watchdog build only).
  task automatic run_inf(input int mode, input int l0, input int l1, input int l2,
                         input int l3, input logic [9:0] cls, input bit inject);
    int lat[NL];
    int k, due, c, t_issue_exp, t_exp, end_c, conv1_c;
    int n_din, first_din, last_din, n_done, t_done;
    int to_chk_c;
    bit rst_hit;
    lat = '{l0, l1, l2, l3};
    k = 0; due = -1; end_c = 0; conv1_c = -1; to_chk_c = -1; rst_hit = 1'b0;
    n_din = 0; first_din = 0; last_din = 0; n_done = 0; t_done = 0;
    t_issue_exp = NP + 2;
    t_exp = 1 + NP + 1;
    for (int i = 0; i < NL; i++) t_exp += 1 + lat[i];

    @(negedge clk);
    start = 1'b1; abort = 1'b0; layer_done = '0; classes_in = cls;
    c = 1;
    while (!(end_c != 0 && c >= end_c)) begin
      @(negedge clk);
      c++;
      start = 1'b0; abort = 1'b0; layer_done = '0;
      classes_in = 10'($urandom_range(1023, 0));

      if (c == 2) begin
        chk("conv1_cleared", 32'(conv1_done), 0);
        chk("busy_on", 32'(busy), 1);
`ifdef BNN_SCHED_TIMEOUT_EN
        chk("err_cleared", 32'(err), 0);
`endif
      end
      if (din_ready) begin
        if (n_din == 0) first_din = c;
        last_din = c;
        n_din++;
      end
      if (layer_start != '0) begin
        chk("layer_start", 32'(layer_start), 32'(1 << k));
        chk("issue_cycle", 32'(c), 32'(t_issue_exp));
`ifdef BNN_SCHED_TIMEOUT_EN
        if (mode == 3 && k == 2) begin
          to_chk_c = c + TO + 1;
          end_c = to_chk_c + 2;
        end
`endif
        due = (mode == 3 && k == 2) ? -1 : c + lat[k];
        k++;
      end
      if (done) begin
        n_done++;
        t_done = c;
        end_c = c + 2;
      end
`ifdef BNN_SCHED_TIMEOUT_EN
      if (c == to_chk_c) begin
        chk("wdog_err", 32'(err), 1);
        chk("wdog_idle", 32'(busy), 0);
      end
`endif
      if (c == conv1_c) chk("conv1_rise", 32'(conv1_done), 1);

      if (mode == 2 && k == 3 && layer_start == '0 && !rst_hit) begin
        // Mid-cycle reset while conv2 is being waited on.
        rst_hit = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        chk("async_rst_cls", 32'(classes), 0);
        chk("async_rst_c1", 32'(conv1_done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("post_rst");
        prev_cls = '0;
        break;
      end

      // Engine responses for this cycle.
      if (due == c) begin
        layer_done = NL'(1 << (k - 1));
        t_issue_exp = c + 1;
        if (k == 1) begin
          chk("conv1_pre", 32'(conv1_done), 0);
          conv1_c = c + 1;
        end
        if (k == NL) classes_in = cls;
        if (mode == 1 && k == NL) begin
          abort = 1'b1;
          end_c = c + 3;
        end
      end
      if (inject && k == 2 && c == due - 1) begin
        layer_done = layer_done | NL'(1 << (NL - 1));
        start = 1'b1;
      end
      if (mode == 1 && c == end_c - 2) chk("abort_idle", 32'(busy), 0);
      if (end_c == 0 && c > t_exp + 100) begin
        chk("cycle_budget", 32'(c), 32'(t_exp));
        end_c = c;
      end
    end

    if (mode != 2) begin
      chk("din_count", 32'(n_din), NP);
      chk("din_first", 32'(first_din), 2);
      chk("din_last", 32'(last_din), NP + 1);
      chk("end_busy", 32'(busy), 0);
    end
    if (mode == 0) begin
      chk("done_count", 32'(n_done), 1);
      chk("latency", 32'(t_done), 32'(t_exp));
      chk("classes", 32'(classes), 32'(cls));
      chk("layers_run", 32'(k), NL);
      prev_cls = cls;
    end else if (mode != 2) begin
      chk("no_done", 32'(n_done), 0);
      chk("classes_hold", 32'(classes), 32'(prev_cls));
    end
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; layer_done = '0; classes_in = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_cls", 32'(classes), 0);
    chk("reset_c1", 32'(conv1_done), 0);
    rst = 1'b0;
    @(negedge clk);

    run_inf(0, 10, 5, 8, 20, 10'h004, 1'b0);
    run_inf(0, 10, 5, 8, 20, 10'h2a9, 1'b1);
    for (int i = 0; i < 3; i++)
      run_inf(0, $urandom_range(20, 2), $urandom_range(20, 2), $urandom_range(20, 2),
              $urandom_range(20, 2), 10'($urandom_range(1023, 0)), i[0]);

    // Abort during pixel 300 of the load window.
    @(negedge clk);
    start = 1'b1;
    repeat (300) @(negedge clk);
    start = 1'b0;
    chk("pix300_din", 32'(din_ready), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load_din", 32'(din_ready), 0);
    chk("abort_load_busy", 32'(busy), 0);
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("abort_load_quiet", 32'(seen_done), 0);
    chk("abort_load_cls", 32'(classes), 32'(prev_cls));

    // start together with abort in IDLE is not accepted.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_din", 32'(din_ready), 0);

    run_inf(1, $urandom_range(12, 2), 3, 4, 6, prev_cls ^ 10'h155, 1'b0);
    run_inf(2, 4, 3, 9, 5, 10'h0f0, 1'b0);
    run_inf(0, 3, 2, 6, 4, 10'($urandom_range(1023, 0)), 1'b0);
`ifdef BNN_SCHED_TIMEOUT_EN
    run_inf(3, 5, 4, 30, 4, prev_cls ^ 10'h3ff, 1'b0);
    run_inf(0, 2, 3, 4, 5, 10'($urandom_range(1023, 0)), 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
